acc_seq_ctrl: RTL and testbench
===============================

// Module: acc_seq_ctrl
// PURPOSE
//  Fetch/decode/execute sequencer for the 8-bit accumulator datapath.
//  - Fetches 8-bit instructions {opcode[7:4], operand[3:0]} over a req/ack memory port.
//  - Drives accumulator load/mux selects, register-file address/write and ALU op.
//  - Owns the PC.
// PARAMETERS
//  PC_W      8      PC / instruction-address width
//  RESET_PC  8'h00  PC value after reset
// PORTS
//  CLK         in   1     clock, all state updates on rising edge
//  CLB         in   1     asynchronous active-low reset
//  run         in   1     IDLE->FETCH start
//  imem_req    out  1     fetch request
//  imem_addr   out  PC_W  fetch address (= pc)
//  imem_ack    in   1     fetch data valid this cycle
//  imem_rdata  in   8     instruction word
//  rf_addr     out  4     register-file address (= ir[3:0])
//  rf_we       out  1     register-file write strobe (STR)
//  alu_op      out  3     ALU function select
//  LoadAcc     out  1     accumulator load enable
//  SelAcc1     out  1     1: ALU result, 0: mux0 output
//  SelAcc0     out  1     1: register file, 0: zero-extended immediate
//  A_imm       out  4     immediate (= ir[3:0])
//  acc_c       in   1     accumulator carry flag
//  acc_z       in   1     accumulator zero flag
//  pc          out  PC_W  current PC
//  halted      out  1     1 while in HALT
// BEHAVIOUR
//  States: IDLE, FETCH, DECODE, EXEC, HALT.
//  Reset (CLB=0, immediate):
//  - state=IDLE, pc=RESET_PC, ir=8'h00.
//  - All strobes (imem_req, rf_we, LoadAcc) = 0; selects and alu_op = 0; halted=0.
//  IDLE: run=1 -> FETCH.
//  FETCH: imem_req=1, imem_addr=pc.
//  - Stalls indefinitely while imem_ack=0.
//  - On ack: ir<=imem_rdata, pc<=pc+1 (FF->00 wrap), -> DECODE.
//  DECODE: rf_addr valid; no strobes; -> EXEC.
//  EXEC: one cycle, then -> FETCH (HALT opcode -> HALT).
//  Outputs are Moore, decoded from state+ir; strobes are high only in EXEC.
//  Opcodes:
//  - 0 NOP.
//  - 1 LDI: LoadAcc, Sel=00.
//  - 2 LDR: LoadAcc, Sel1=0 Sel0=1.
//  - 3 STR: rf_we.
//  - 4..8 ADD/SUB/AND/OR/XOR: LoadAcc, Sel1=1, alu_op=0..4.
//  - 9 JMP: pc<={pc[PC_W-1:4], imm} (in-page).
//  - A JZ / B JC: branch-option dependent (see CONFIGURATION).
//  - F HALT.
//  - C..E: NOP.
//  Flags are sampled in EXEC only; they reflect the last EXEC that loaded the accumulator.
//  Simultaneous events:
//  - JMP in EXEC overrides the FETCH-time increment.
//  - run is ignored outside IDLE.
//  HALT: halted=1, no strobes, exits only via CLB.
//  Reset mid-FETCH: imem_req drops immediately; a late imem_ack after reset is ignored in IDLE.
//  Instruction latency: 3 cycles plus ack wait.
// CONFIGURATION
//  ACC_SEQ_CTRL_BRANCH_EN
//  - Defined: JZ loads pc<={pc[PC_W-1:4], imm} iff acc_z=1; JC does the same iff acc_c=1.
//  - Undefined: JZ/JC execute as NOP, pc unchanged; decoder logic for them is absent.
// STRUCTURE
//  Shared package mcu_pkg:
//  - Opcode localparams (OP_NOP..OP_HALT).
//  - ALU_ADD..ALU_XOR encodings.
//  - State encodings.
//  Sub-module acc_seq_decode:
//  - Combinational ir+state -> {LoadAcc, SelAcc1, SelAcc0, alu_op, rf_we, is_jmp, is_halt}.
//  - Instantiated once.
//  Top holds the FSM, pc and ir.
// TESTING
//  1 Reset: CLB=0 mid-FETCH -> imem_req=0, pc=00, state IDLE; ack ignored until run.
//  2 ack delayed 3 cycles, LDI 5 (8'h15) -> LoadAcc=1 Sel=00 A_imm=5 one cycle; pc=01.
//  3 ADD r3 (8'h43) -> rf_addr=3 in DECODE/EXEC, LoadAcc=1, SelAcc1=1, alu_op=0; STR r2 -> rf_we one cycle.
//  4 JMP 4 at pc=8'h2E -> next imem_addr=8'h24; pc=FF fetch -> pc wraps to 00.
//  5 JZ 7 with acc_z=1 / acc_z=0 -> pc=x7 / sequential with _BRANCH_EN; always sequential without.
//  6 HALT (8'hF0) -> halted=1, no imem_req for 20 cycles; CLB pulse -> IDLE, halted=0.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared definitions for the accumulator MCU sequencer.
//   - Opcode encodings (instruction bits [7:4])
//   - ALU function select encodings
//   - Sequencer state encodings
package mcu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDR  = 4'h2;
  localparam logic [3:0] OP_STR  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JC   = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/acc_seq_decode.sv
// Combinational instruction decoder for acc_seq_ctrl.
// Every output is zero outside EXEC, so strobes and selects can only be
// active for exactly one cycle per instruction.
// Optional feature macro: ACC_SEQ_CTRL_BRANCH_EN (conditional JZ/JC).
// Ports:
//   state    in   sequencer state
//   opcode   in   ir[7:4]
//   acc_z/c  in   accumulator flags (branch build only)
//   load_acc, sel_acc1, sel_acc0, alu_op, rf_we   out  datapath controls
//   is_jmp   out  load the in-page target into pc this cycle
//   is_halt  out  EXEC is a HALT
module acc_seq_decode
  import mcu_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
`ifdef ACC_SEQ_CTRL_BRANCH_EN
  input  logic       acc_z,
  input  logic       acc_c,
`endif
  output logic       load_acc,
  output logic       sel_acc1,
  output logic       sel_acc0,
  output logic [2:0] alu_op,
  output logic       rf_we,
  output logic       is_jmp,
  output logic       is_halt
);

  always_comb begin
    load_acc = 1'b0;
    sel_acc1 = 1'b0;
    sel_acc0 = 1'b0;
    alu_op   = ALU_ADD;
    rf_we    = 1'b0;
    is_jmp   = 1'b0;
    is_halt  = 1'b0;
    if (state == ST_EXEC) begin
      case (opcode)
        OP_NOP:  ;
        OP_LDI:  load_acc = 1'b1;
        OP_LDR:  begin load_acc = 1'b1; sel_acc0 = 1'b1; end
        OP_STR:  rf_we = 1'b1;
        OP_ADD:  begin load_acc = 1'b1; sel_acc1 = 1'b1; alu_op = ALU_ADD; end
        OP_SUB:  begin load_acc = 1'b1; sel_acc1 = 1'b1; alu_op = ALU_SUB; end
        OP_AND:  begin load_acc = 1'b1; sel_acc1 = 1'b1; alu_op = ALU_AND; end
        OP_OR:   begin load_acc = 1'b1; sel_acc1 = 1'b1; alu_op = ALU_OR;  end
        OP_XOR:  begin load_acc = 1'b1; sel_acc1 = 1'b1; alu_op = ALU_XOR; end
        OP_JMP:  is_jmp = 1'b1;
`ifdef ACC_SEQ_CTRL_BRANCH_EN
        OP_JZ:   is_jmp = acc_z;
        OP_JC:   is_jmp = acc_c;
`else
        // Without branch support these behave exactly like NOP.
        OP_JZ, OP_JC: ;
`endif
        OP_HALT: is_halt = 1'b1;
        default: ;  // C..E are NOPs
      endcase
    end
  end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator datapath.
// Owns the FSM, pc and instruction register; control outputs are Moore,
// decoded from state+ir by acc_seq_decode.
// Optional feature macro: ACC_SEQ_CTRL_BRANCH_EN (conditional JZ/JC).
// Ports:
//   CLK, CLB (async active-low)          clock / reset
//   run                                   start from IDLE
//   imem_req/addr/ack/rdata               instruction fetch port
//   rf_addr, rf_we                        register file control
//   alu_op, LoadAcc, SelAcc1, SelAcc0     accumulator control
//   A_imm                                 immediate (ir[3:0])
//   acc_c, acc_z                          accumulator flags
//   pc, halted                            status
// PC_W must be at least 5 (jumps replace the low nibble only).
module acc_seq_ctrl
  import mcu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            CLB,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_rdata,
  output logic [3:0]      rf_addr,
  output logic            rf_we,
  output logic [2:0]      alu_op,
  output logic            LoadAcc,
  output logic            SelAcc1,
  output logic            SelAcc0,
  output logic [3:0]      A_imm,
  input  logic            acc_c,
  input  logic            acc_z,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  state_t     state;
  logic [7:0] ir;
  logic       is_jmp, is_halt;

  acc_seq_decode u_dec (
    .state    (state),
    .opcode   (ir[7:4]),
`ifdef ACC_SEQ_CTRL_BRANCH_EN
    .acc_z    (acc_z),
    .acc_c    (acc_c),
`endif
    .load_acc (LoadAcc),
    .sel_acc1 (SelAcc1),
    .sel_acc0 (SelAcc0),
    .alu_op   (alu_op),
    .rf_we    (rf_we),
    .is_jmp   (is_jmp),
    .is_halt  (is_halt)
  );

`ifndef ACC_SEQ_CTRL_BRANCH_EN
  // Flags only matter for conditional branches.
  logic unused_flags;
  assign unused_flags = acc_c ^ acc_z;
`endif

  // Derived from state so a reset during FETCH drops the request at once.
  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;
  assign rf_addr   = ir[3:0];
  assign A_imm     = ir[3:0];
  assign halted    = (state == ST_HALT);

  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
      ir    <= 8'h00;
    end else begin
      case (state)
        ST_IDLE:   if (run) state <= ST_FETCH;
        ST_FETCH:  if (imem_ack) begin
                     ir    <= imem_rdata;
                     pc    <= pc + 1'b1;
                     state <= ST_DECODE;
                   end
        ST_DECODE: state <= ST_EXEC;
        ST_EXEC: begin
          // Target keeps the page of the already-incremented pc.
          if (is_jmp) pc <= {pc[PC_W-1:4], ir[3:0]};
          state <= is_halt ? ST_HALT : ST_FETCH;
        end
        ST_HALT:   state <= ST_HALT;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
module tb_acc_seq_ctrl;

`ifdef ACC_SEQ_CTRL_BRANCH_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       CLB = 1'b0;
  logic       run = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_rdata = 8'h00;
  logic [3:0] rf_addr;
  logic       rf_we;
  logic [2:0] alu_op;
  logic       LoadAcc, SelAcc1, SelAcc0;
  logic [3:0] A_imm;
  logic       acc_c = 1'b0;
  logic       acc_z = 1'b0;
  logic [7:0] pc;
  logic       halted;

  acc_seq_ctrl #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .CLK(CLK), .CLB(CLB), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .rf_addr(rf_addr), .rf_we(rf_we),
    .alu_op(alu_op), .LoadAcc(LoadAcc), .SelAcc1(SelAcc1), .SelAcc0(SelAcc0),
    .A_imm(A_imm), .acc_c(acc_c), .acc_z(acc_z), .pc(pc), .halted(halted)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       la, s1, s0;
    logic [2:0] op;
    logic       we;
    logic [3:0] addr, imm;
    logic [7:0] npc;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] cur   = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input bit la, input bit s1, input bit s0,
                              input bit [2:0] op, input bit we,
                              input bit [7:0] instr, input bit [7:0] npc);
    exp_t e;
    e.la = la; e.s1 = s1; e.s0 = s0; e.op = op; e.we = we;
    e.addr = instr[3:0]; e.imm = instr[3:0]; e.npc = npc;
    return e;
  endfunction

  // In-page jump target: page of the incremented pc, low nibble = imm.
  function automatic logic [7:0] jt(input logic [7:0] a, input logic [3:0] imm);
    logic [7:0] nx;
    nx = a + 8'd1;
    return {nx[7:4], imm};
  endfunction

  // Serve one fetch at the expected address after dly stall cycles.
  task automatic issue(input logic [7:0] instr, input int dly, input exp_t e);
    int n = 0;
    while (!imem_req && n < 50) begin @(posedge CLK); #1; n++; end
    if (!imem_req) begin
      total++; bad++;
      $display("FAIL req_timeout: got no imem_req want imem_req at %0h", cur);
      return;
    end
    chk("imem_addr", imem_addr, cur);
    for (int i = 0; i < dly; i++) begin
      @(posedge CLK); #1;
      chk("stall_req", {imem_req, pc}, {1'b1, cur});
    end
    sb.push_back(e);
    imem_ack = 1'b1; imem_rdata = instr;
    @(posedge CLK); #1;
    imem_ack = 1'b0; imem_rdata = 8'h00;
    cur = e.npc;
  endtask

  // Monitor: a fetch handshake is followed by DECODE then EXEC; the EXEC
  // controls are popped against the scoreboard, and the pc one cycle later.
  initial begin
    int         cd = 0;
    bit         pcchk = 0;
    logic [7:0] epc = 8'h00;
    exp_t       e;
    forever begin
      @(negedge CLK);
      if (!CLB) begin
        cd = 0; pcchk = 0;
      end else begin
        if (pcchk) begin
          chk("post_exec", {LoadAcc, rf_we, pc}, {2'b00, epc});
          pcchk = 0;
        end
        if (cd == 1) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_empty: got EXEC want no pending instruction");
          end else begin
            e = sb.pop_front();
            chk("exec_ctl",
                {LoadAcc, SelAcc1, SelAcc0, alu_op, rf_we, rf_addr, A_imm, halted, imem_req},
                {e.la, e.s1, e.s0, e.op, e.we, e.addr, e.imm, 2'b00});
            epc = e.npc; pcchk = 1;
          end
          cd = 0;
        end else if (cd == 2) begin
          if (sb.size() != 0)
            chk("decode_ctl", {LoadAcc, rf_we, imem_req, SelAcc1, SelAcc0, rf_addr},
                {5'b0, sb[0].addr});
          cd = 1;
        end else if (imem_req && imem_ack) begin
          cd = 2;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqs;
    // Reset state
    repeat (2) @(posedge CLK);
    #1 CLB = 1'b1;
    chk("rst_state", {imem_req, rf_we, LoadAcc, SelAcc1, SelAcc0, alu_op, halted, pc},
        {10'b0, 8'h00});
    // Reset during FETCH; late ack ignored in IDLE
    run = 1'b1; @(posedge CLK); #1 run = 1'b0;
    chk("fetch_req", {imem_req, imem_addr}, {1'b1, 8'h00});
    CLB = 1'b0; #1;
    chk("rst_midfetch", {imem_req, halted, pc}, {2'b00, 8'h00});
    imem_ack = 1'b1; imem_rdata = 8'h9F;
    @(posedge CLK); #1 CLB = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("idle_ack_ignored", {imem_req, LoadAcc, pc}, {2'b00, 8'h00});
    end
    imem_ack = 1'b0; imem_rdata = 8'h00;
    run = 1'b1; @(posedge CLK); #1 run = 1'b0;

    // Data/ALU ops
    issue(8'h15, 3, mk(1, 0, 0, 3'd0, 0, 8'h15, 8'h01));  // LDI 5
    run = 1'b1;                                           // ignored outside IDLE
    issue(8'h43, 0, mk(1, 1, 0, 3'd0, 0, 8'h43, 8'h02));  // ADD r3
    run = 1'b0;
    issue(8'h32, 1, mk(0, 0, 0, 3'd0, 1, 8'h32, 8'h03));  // STR r2
    issue(8'h27, 0, mk(1, 0, 1, 3'd0, 0, 8'h27, 8'h04));  // LDR r7
    issue(8'h51, 0, mk(1, 1, 0, 3'd1, 0, 8'h51, 8'h05));  // SUB
    issue(8'h86, 2, mk(1, 1, 0, 3'd4, 0, 8'h86, 8'h06));  // XOR
    issue(8'hC5, 0, mk(0, 0, 0, 3'd0, 0, 8'hC5, 8'h07));  // C = NOP
    issue(8'h6A, 0, mk(1, 1, 0, 3'd2, 0, 8'h6A, 8'h08));  // AND
    issue(8'h7B, 0, mk(1, 1, 0, 3'd3, 0, 8'h7B, 8'h09));  // OR

    // Jumps up to 2E, then JMP 4 there
    issue(8'h9F, 0, mk(0, 0, 0, 3'd0, 0, 8'h9F, 8'h0F));
    issue(8'h00, 0, mk(0, 0, 0, 3'd0, 0, 8'h00, 8'h10));
    issue(8'h9E, 0, mk(0, 0, 0, 3'd0, 0, 8'h9E, 8'h1E));
    issue(8'h00, 0, mk(0, 0, 0, 3'd0, 0, 8'h00, 8'h1F));
    issue(8'h00, 0, mk(0, 0, 0, 3'd0, 0, 8'h00, 8'h20));
    issue(8'h9E, 0, mk(0, 0, 0, 3'd0, 0, 8'h9E, 8'h2E));
    issue(8'h94, 0, mk(0, 0, 0, 3'd0, 0, 8'h94, 8'h24));
    issue(8'h9F, 0, mk(0, 0, 0, 3'd0, 0, 8'h9F, 8'h2F));
    // Walk pages to FF: NOP at xF crosses page, JMP F at x0
    for (int p = 2; p <= 15; p++) begin
      logic [3:0] nib;
      nib = 4'(p + 1);
      issue(8'h00, 0, mk(0, 0, 0, 3'd0, 0, 8'h00, {nib, 4'h0}));
      if (p < 15) issue(8'h9F, 0, mk(0, 0, 0, 3'd0, 0, 8'h9F, {nib, 4'hF}));
    end
    @(posedge CLK); #1;
    chk("pc_wrap", pc, 8'h00);

    // Conditional branches
    acc_z = 1'b1;
    issue(8'hA7, 0, mk(0, 0, 0, 3'd0, 0, 8'hA7, BR ? jt(cur, 4'h7) : cur + 8'd1));
    acc_z = 1'b0;
    issue(8'hA3, 0, mk(0, 0, 0, 3'd0, 0, 8'hA3, cur + 8'd1));
    acc_c = 1'b1;
    issue(8'hB2, 1, mk(0, 0, 0, 3'd0, 0, 8'hB2, BR ? jt(cur, 4'h2) : cur + 8'd1));
    acc_c = 1'b0; acc_z = 1'b1;
    issue(8'hB9, 0, mk(0, 0, 0, 3'd0, 0, 8'hB9, cur + 8'd1));
    acc_z = 1'b0;

    // HALT
    issue(8'hF0, 0, mk(0, 0, 0, 3'd0, 0, 8'hF0, cur + 8'd1));
    repeat (2) @(posedge CLK);
    #1 chk("halted", {halted, LoadAcc, rf_we}, 3'b100);
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (imem_req) reqs++;
    end
    chk("halt_no_req", reqs, 0);
    run = 1'b1; @(posedge CLK); #1 run = 1'b0;
    chk("halt_run_ignored", {halted, imem_req}, 2'b10);
    CLB = 1'b0; #1;
    chk("halt_reset", {halted, imem_req, pc}, {2'b00, 8'h00});
    @(posedge CLK); #1 CLB = 1'b1;
    @(posedge CLK); #1;
    chk("idle_after_reset", {halted, imem_req}, 2'b00);
    cur = 8'h00;
    run = 1'b1; @(posedge CLK); #1 run = 1'b0;
    issue(8'h1A, 0, mk(1, 0, 0, 3'd0, 0, 8'h1A, 8'h01));
    repeat (4) @(posedge CLK);
    #1 chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
